// File: rtl/metronome_tone.sv
`default_nettype none
// ============================================================================
// Module   : metronome_tone
// Purpose  : Turns metronome beat strobes into fixed-length square-wave tone
//            bursts, with an accented pitch on the first beat of each bar.
// Revision : 1.0 - initial release
// ============================================================================
module metronome_tone #(
    parameter int FREQ          = 24_000_000,
    parameter int ACCENT_HZ     = 1760,
    parameter int NORMAL_HZ     = 880,
    parameter int BEEP_MS       = 60,
    parameter int BEATS_PER_BAR = 4
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       beat,
    input  logic       bar_sync,
    input  logic       mute,
    output logic       speaker,
    output logic       busy,
    output logic [1:0] beat_pos
);

    localparam int HALF_ACC    = FREQ / (2 * ACCENT_HZ);
    localparam int HALF_NRM    = FREQ / (2 * NORMAL_HZ);
    localparam int BEEP_CYCLES = (FREQ / 1000) * BEEP_MS;
    localparam int HALF_MAX    = (HALF_ACC > HALF_NRM) ? HALF_ACC : HALF_NRM;
    localparam int HALF_W      = (HALF_MAX > 1) ? $clog2(HALF_MAX) : 1;
    localparam int DUR_W       = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;

    localparam logic [HALF_W-1:0] ACC_LIM  = HALF_W'(HALF_ACC - 1);
    localparam logic [HALF_W-1:0] NRM_LIM  = HALF_W'(HALF_NRM - 1);
    localparam logic [DUR_W-1:0]  DUR_LAST = DUR_W'(BEEP_CYCLES - 1);
    localparam logic [1:0]        LAST_POS = 2'(BEATS_PER_BAR - 1);

    generate
        if (HALF_ACC < 1 || HALF_NRM < 1 || BEEP_CYCLES < 2 * HALF_NRM ||
            BEATS_PER_BAR < 1 || BEATS_PER_BAR > 4) begin : g_bad_params
            $error("metronome_tone: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        TONE = 1'b1
    } state_t;

    state_t            state_q,    state_d;
    logic              tone_q,     tone_d;
    logic              speaker_q,  speaker_d;
    logic              busy_q,     busy_d;
    logic [1:0]        beat_pos_q, beat_pos_d;
    logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
    logic [HALF_W-1:0] half_lim_q, half_lim_d;
    logic [DUR_W-1:0]  dur_cnt_q,  dur_cnt_d;
    logic [1:0]        pos_eff;

    always_comb begin
        state_d    = state_q;
        tone_d     = tone_q;
        half_cnt_d = half_cnt_q;
        half_lim_d = half_lim_q;
        dur_cnt_d  = dur_cnt_q;
        beat_pos_d = beat_pos_q;

        // bar_sync on the same edge as a beat makes that beat the downbeat
        pos_eff = bar_sync ? 2'd0 : beat_pos_q;

        if (beat) begin
            state_d    = TONE;
            tone_d     = 1'b0;
            half_cnt_d = '0;
            dur_cnt_d  = '0;
            half_lim_d = (pos_eff == 2'd0) ? ACC_LIM : NRM_LIM;
            beat_pos_d = (pos_eff == LAST_POS) ? 2'd0 : pos_eff + 2'd1;
        end else begin
            beat_pos_d = pos_eff;
            if (state_q == TONE) begin
                if (dur_cnt_q == DUR_LAST) begin
                    state_d    = IDLE;
                    tone_d     = 1'b1;
                    half_cnt_d = '0;
                    dur_cnt_d  = '0;
                end else begin
                    dur_cnt_d = dur_cnt_q + DUR_W'(1);
                    if (half_cnt_q == half_lim_q) begin
                        tone_d     = ~tone_q;
                        half_cnt_d = '0;
                    end else begin
                        half_cnt_d = half_cnt_q + HALF_W'(1);
                    end
                end
            end
        end

        // mute only masks the pin; tone_q keeps the phase running underneath
        speaker_d = mute | tone_d;
        busy_d    = (state_d == TONE);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            tone_q     <= 1'b1;
            speaker_q  <= 1'b1;
            busy_q     <= 1'b0;
            beat_pos_q <= 2'd0;
            half_cnt_q <= '0;
            half_lim_q <= '0;
            dur_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            tone_q     <= tone_d;
            speaker_q  <= speaker_d;
            busy_q     <= busy_d;
            beat_pos_q <= beat_pos_d;
            half_cnt_q <= half_cnt_d;
            half_lim_q <= half_lim_d;
            dur_cnt_q  <= dur_cnt_d;
        end
    end

    assign speaker  = speaker_q;
    assign busy     = busy_q;
    assign beat_pos = beat_pos_q;

endmodule
`default_nettype wire

// File: tb/tb_metronome_tone.sv
`default_nettype none
// ============================================================================
// Module   : tb_metronome_tone
// Purpose  : Self-checking bench for metronome_tone (vector table, directed
//            corner sequences and random traffic against a burst model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_metronome_tone;

    localparam int HALF_A = 5;
    localparam int HALF_N = 10;
    localparam int BEEP   = 40;
    localparam int BPB    = 4;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic       beat = 1'b0;
    logic       bar_sync = 1'b0;
    logic       mute = 1'b0;
    logic       speaker;
    logic       busy;
    logic [1:0] beat_pos;

    metronome_tone #(
        .FREQ          (1000),
        .ACCENT_HZ     (100),
        .NORMAL_HZ     (50),
        .BEEP_MS       (40),
        .BEATS_PER_BAR (BPB)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .beat     (beat),
        .bar_sync (bar_sync),
        .mute     (mute),
        .speaker  (speaker),
        .busy     (busy),
        .beat_pos (beat_pos)
    );

    always #5 sys_clk = ~sys_clk;

    int checks   = 0;
    int failures = 0;

    // burst model: elapsed cycles since the beat, latched half period, bar position
    bit m_in_burst = 0;
    int m_k        = 0;
    int m_half     = HALF_A;
    int m_pos      = 0;
    bit m_mute     = 0;

    // per-sequence tallies
    int  low_run   = 0;
    bit  seen_high = 0;
    int  busy_len  = 0;
    int  muted_low = 0;

    typedef struct {
        logic       rst;
        logic       bt;
        logic       bs;
        logic       mt;
        logic       spk;
        logic       bsy;
        logic [1:0] pos;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tally_reset();
        low_run   = 0;
        seen_high = 0;
        busy_len  = 0;
        muted_low = 0;
    endtask

    task automatic step(input logic r, input logic b, input logic s, input logic m);
        int p;
        logic exp_spk;
        sys_rst  = r;
        beat     = b;
        bar_sync = s;
        mute     = m;
        @(posedge sys_clk);
        if (r) begin
            m_in_burst = 0;
            m_pos      = 0;
        end else if (b) begin
            p          = s ? 0 : m_pos;
            m_half     = (p == 0) ? HALF_A : HALF_N;
            m_k        = 0;
            m_in_burst = 1;
            m_pos      = (p + 1) % BPB;
        end else begin
            if (s) m_pos = 0;
            if (m_in_burst) begin
                m_k++;
                if (m_k >= BEEP) m_in_burst = 0;
            end
        end
        m_mute = m;
        exp_spk = (!m_in_burst || (m_mute && !r)) ? 1'b1 : 1'(((m_k / m_half) % 2));
        #1;
        chk("model_speaker", 32'(speaker), 32'(exp_spk));
        chk("model_busy", 32'(busy), 32'(m_in_burst));
        chk("model_beat_pos", 32'(beat_pos), 32'(m_pos));
        if (busy) busy_len++;
        if (speaker == 1'b0 && !seen_high) low_run++;
        else if (low_run > 0) seen_high = 1;
        if (m && speaker == 1'b0) muted_low++;
    endtask

    task automatic idle(input int n, input logic m);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, m);
    endtask

    initial begin
        //         rst   beat  bsync mute  spk   busy  pos
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 2'd0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0};

        for (int i = 0; i < 13; i++) begin
            step(tbl[i].rst, tbl[i].bt, tbl[i].bs, tbl[i].mt);
            chk($sformatf("vec%0d_speaker", i), 32'(speaker), 32'(tbl[i].spk));
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].bsy));
            chk($sformatf("vec%0d_beat_pos", i), 32'(beat_pos), 32'(tbl[i].pos));
        end

        // single accented burst: 5-cycle half period, 40 busy cycles
        step(1'b1, 1'b0, 1'b0, 1'b0);
        tally_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(59, 1'b0);
        chk("t1_low_run", 32'(low_run), 32'(HALF_A));
        chk("t1_busy_len", 32'(busy_len), 32'(BEEP));
        chk("t1_pos", 32'(beat_pos), 32'd1);

        // a full bar plus one: accent, normal, normal, normal, accent
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int b = 0; b < 5; b++) begin
            tally_reset();
            step(1'b0, 1'b1, 1'b0, 1'b0);
            idle(59, 1'b0);
            chk($sformatf("t2_low_run_%0d", b), 32'(low_run),
                32'((b % 4 == 0) ? HALF_A : HALF_N));
            chk($sformatf("t2_pos_%0d", b), 32'(beat_pos), 32'((b + 1) % 4));
        end

        // retrigger 15 cycles in
        step(1'b1, 1'b0, 1'b0, 1'b0);
        tally_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(14, 1'b0);
        chk("t3_first_busy", 32'(busy_len), 32'd15);
        tally_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(59, 1'b0);
        chk("t3_low_run", 32'(low_run), 32'(HALF_N));
        chk("t3_busy_after", 32'(busy_len), 32'(BEEP));
        chk("t3_pos", 32'(beat_pos), 32'd2);

        // muted beat, mute released at cycle 20 of the burst
        step(1'b1, 1'b0, 1'b0, 1'b0);
        tally_reset();
        step(1'b0, 1'b1, 1'b0, 1'b1);
        idle(19, 1'b1);
        chk("t4_muted_low", 32'(muted_low), 32'd0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_resume_phase", 32'(speaker), 32'd0);
        idle(39, 1'b0);
        chk("t4_busy_len", 32'(busy_len), 32'(BEEP));
        chk("t4_pos", 32'(beat_pos), 32'd1);

        // bar_sync with a beat, then bar_sync alone mid-burst
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        tally_reset();
        step(1'b0, 1'b1, 1'b1, 1'b0);
        idle(12, 1'b0);
        chk("t5_sync_low_run", 32'(low_run), 32'(HALF_A));
        chk("t5_sync_pos", 32'(beat_pos), 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(6, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5_alone_pos", 32'(beat_pos), 32'd0);
        chk("t5_alone_busy", 32'(busy), 32'd1);
        idle(40, 1'b0);

        // reset in the middle of a burst
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(11, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t6_speaker", 32'(speaker), 32'd1);
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_pos", 32'(beat_pos), 32'd0);
        tally_reset();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(20, 1'b0);
        chk("t6_low_run", 32'(low_run), 32'(HALF_A));

        // random traffic against the model
        begin
            logic rm;
            rm = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 79) == 0) rm = ~rm;
                step(1'($urandom_range(0, 699) == 0),
                     1'($urandom_range(0, 39) == 0),
                     1'($urandom_range(0, 59) == 0),
                     rm);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
